heater_duty_scheduler: RTL and testbench
========================================

# heater_duty_scheduler

Sequences the self-heating fabric by turning heater banks on and off in a fixed duty-cycle pattern. It sits between the AXI4-Lite register file of the heater IP and the heater banks. It rotates one bank at a time through the enabled set, so the instantaneous toggle load stays bounded. Configuration is double-buffered and only takes effect on period boundaries, so a register write never produces a truncated or runt heating pulse.

## Interface
- N_BANKS, 4: number of heater banks; must be 2..32.
- CNT_W, 32: width of the cycle counters and of the period counter.

- clock  in  1  single clock for all logic.
- reset  in  1  synchronous reset, active-high.
- cfg_enable  in  1  level; 1 = run the schedule, 0 = stop immediately.
- cfg_on_cycles  in  CNT_W  number of ON cycles per period.
- cfg_period  in  CNT_W  total cycles per period.
- cfg_bank_mask  in  N_BANKS  banks that take part in the rotation.
- cfg_load  in  1  one-cycle pulse; captures the three cfg_* value inputs.
- heat_en  out  N_BANKS  registered one-hot (or zero) enable to the heater banks.
- busy  out  1  1 while the block is in ON or OFF.
- period_count  out  CNT_W  number of completed periods; wraps at 2^CNT_W.
- cfg_err  out  1  sticky; set by an invalid load; cleared by the next valid load or by reset.

## Operation
- **Reset values:** heat_en=0, busy=0, period_count=0, cfg_err=0, state=IDLE. The active configuration is cleared (period=0, mask=0) and there is no pending configuration.
- **Load validation:** a load is valid only if all of the following hold:
  - cfg_period != 0;
  - cfg_on_cycles <= cfg_period;
  - cfg_bank_mask != 0.
- **Invalid load:** cfg_err is set, the pending slot is left unchanged and the active configuration is untouched.
- **Valid load:** cfg_err is cleared.
  - In IDLE, the load is written straight into the active configuration.
  - Otherwise it goes into the pending slot. A later load overwrites the slot.
- **States:**
  - IDLE: heat_en=0.
    - Goes to ON when cfg_enable=1 and the active configuration is valid.
    - The cycle counter cnt is set to 0 and the bank pointer is set to the lowest set mask bit.
  - ON: heat_en = one-hot(bank).
    - cnt increments every cycle.
    - When cnt = on_cycles-1, go to OFF. If on_cycles = period, stay ON through the whole period instead.
  - OFF: heat_en=0.
    - cnt increments every cycle.
    - At cnt = period-1 the period ends.
- **Period end** (the last cycle of a period, entered from ON or OFF):
  - period_count increments.
  - The pending configuration, if any, is promoted to active and the slot is cleared.
  - The bank pointer advances to the next set bit of the now-active mask, strictly above the current one and wrapping to the lowest. If the mask has exactly one bit, it stays on that bank.
  - cnt returns to 0.
  - The next state is ON, or OFF when on_cycles = 0.
- **on_cycles = 0:** the block never enters ON; it stays in OFF for whole periods and still rotates banks and counts periods.
- **cfg_enable = 0 in ON or OFF:** the next state is IDLE and heat_en=0 from the next cycle. The partial period is not counted. The pending configuration is promoted on that IDLE entry.
- **Simultaneous events:** when a cfg_load arrives in the period-end cycle, the promotion uses the pending value as it was before that cycle. The new load goes into the slot and applies one period later.

## Timing
- heat_en, busy and period_count are all registered.
- Start latency: a cycle with cfg_enable=1 in IDLE gives heat_en!=0 in the next cycle (on_cycles>0).
- With on_cycles in 1..period-1, heat_en is high for exactly on_cycles consecutive cycles per period. Each period is exactly `period` cycles long.
- Stop latency: one cycle from cfg_enable falling to heat_en=0.
- In IDLE, a configuration loaded in cycle t is active in cycle t+1.
- reset in any cycle overrides everything else. It returns all outputs to their reset values in the next cycle, including in the middle of a period.

## Test plan
- **Basic schedule:** load on=3, period=8, mask=4'b1111, then enable. Expect heat_en = 0001 for 3 cycles and 0 for 5, then 0010, 0100, 1000, then wrap to 0001. period_count reads 4 after 32 cycles.
- **Sparse mask / edge duties:** mask=4'b1010 with on=period=5 gives heat_en alternating 0010 and 1000 every 5 cycles with no gaps. Then on=0 with period=4 gives heat_en permanently 0 while period_count still increments every 4 cycles.
- **Mid-period reload:** running on=2, period=6; at cycle 3 of a period, load on=4, period=4. The current period completes with the old values (6 cycles). The following periods are 4 cycles long, all of them ON.
- **Invalid loads:** load period=0, then on=9 with period=8, then mask=0. cfg_err=1 after each and the schedule continues unchanged. A following valid load clears cfg_err.
- **Stop and reset:** drop cfg_enable in the middle of ON; heat_en=0 and busy=0 on the next cycle and period_count does not change. Re-enable and the block restarts at the lowest mask bit. Assert reset in the middle of OFF; all outputs return to 0 and the block stays in IDLE even with cfg_enable=1 until a valid load.
- **Counter wrap:** with CNT_W=4 and period=1, period_count wraps from 15 to 0 without disturbing heat_en.

Source files
------------

// File: rtl/heater_duty_scheduler_if.sv
// Configuration and status bundle between the heater register file (master)
// and the duty scheduler (slave).
interface heater_duty_scheduler_if #(
  parameter int unsigned N_BANKS = 4,
  parameter int unsigned CNT_W   = 32
);
  logic               cfg_enable;
  logic [CNT_W-1:0]   cfg_on_cycles;
  logic [CNT_W-1:0]   cfg_period;
  logic [N_BANKS-1:0] cfg_bank_mask;
  logic               cfg_load;
  logic [N_BANKS-1:0] heat_en;
  logic               busy;
  logic [CNT_W-1:0]   period_count;
  logic               cfg_err;

  modport master (
    output cfg_enable,
    output cfg_on_cycles,
    output cfg_period,
    output cfg_bank_mask,
    output cfg_load,
    input  heat_en,
    input  busy,
    input  period_count,
    input  cfg_err
  );

  modport slave (
    input  cfg_enable,
    input  cfg_on_cycles,
    input  cfg_period,
    input  cfg_bank_mask,
    input  cfg_load,
    output heat_en,
    output busy,
    output period_count,
    output cfg_err
  );
endinterface

// File: rtl/heater_duty_scheduler.sv
// Heater duty scheduler: rotates one heater bank at a time through the enabled
// set with a fixed ON/OFF duty pattern. Configuration is double-buffered and
// only swapped in at period boundaries (or on return to idle).
module heater_duty_scheduler #(
  parameter int unsigned N_BANKS = 4,
  parameter int unsigned CNT_W   = 32
) (
  input logic                    clock,
  input logic                    reset,
  heater_duty_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   bank;

  // Active configuration
  logic [CNT_W-1:0]   act_on;
  logic [CNT_W-1:0]   act_period;
  logic [N_BANKS-1:0] act_mask;

  // Pending slot, promoted at the next period end or idle entry
  logic               pend_valid;
  logic [CNT_W-1:0]   pend_on;
  logic [CNT_W-1:0]   pend_period;
  logic [N_BANKS-1:0] pend_mask;

  // Registered outputs
  logic [N_BANKS-1:0] heat_en;
  logic               busy;
  logic [CNT_W-1:0]   period_count;
  logic               cfg_err;

  assign bus.heat_en      = heat_en;
  assign bus.busy         = busy;
  assign bus.period_count = period_count;
  assign bus.cfg_err      = cfg_err;

  // Lowest set bit of a mask (0 for an empty mask).
  function automatic logic [IDX_W-1:0] lowest_bit(input logic [N_BANKS-1:0] m);
    lowest_bit = '0;
    for (int i = int'(N_BANKS) - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = IDX_W'(i);
    end
  endfunction

  // Next set bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [IDX_W-1:0] next_bit(input logic [N_BANKS-1:0] m,
                                                input logic [IDX_W-1:0]   cur);
    logic found;
    next_bit = lowest_bit(m);
    found    = 1'b0;
    for (int i = 0; i < int'(N_BANKS); i++) begin
      if (!found && m[i] && (i > int'(cur))) begin
        next_bit = IDX_W'(i);
        found    = 1'b1;
      end
    end
  endfunction

  function automatic logic [N_BANKS-1:0] onehot(input logic [IDX_W-1:0] b);
    onehot    = '0;
    onehot[b] = 1'b1;
  endfunction

  logic               load_ok;
  logic               act_ok;
  logic               full_on;
  logic               on_last;
  logic               period_last;
  logic               period_end;
  logic [CNT_W-1:0]   nxt_on;
  logic [N_BANKS-1:0] nxt_mask;
  logic [IDX_W-1:0]   start_bank;
  logic [IDX_W-1:0]   adv_bank;

  // Load validation, period boundary detection and next-bank selection.
  always_comb begin
    load_ok = (bus.cfg_period != '0) && (bus.cfg_on_cycles <= bus.cfg_period) &&
              (bus.cfg_bank_mask != '0);
    act_ok      = (act_period != '0) && (act_mask != '0);
    full_on     = (act_on == act_period);
    on_last     = (cnt == act_on - CNT_W'(1));
    period_last = (cnt == act_period - CNT_W'(1));
    period_end  = ((state == StOn) && full_on && period_last) ||
                  ((state == StOff) && period_last);
    // The period after a boundary runs with whatever is active once the
    // pending slot has been promoted.
    nxt_on      = pend_valid ? pend_on : act_on;
    nxt_mask    = pend_valid ? pend_mask : act_mask;
    start_bank  = lowest_bit(act_mask);
    adv_bank    = next_bit(nxt_mask, bank);
  end

  // Scheduler FSM with configuration buffering and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= '0;
      bank         <= '0;
      act_on       <= '0;
      act_period   <= '0;
      act_mask     <= '0;
      pend_valid   <= 1'b0;
      pend_on      <= '0;
      pend_period  <= '0;
      pend_mask    <= '0;
      heat_en      <= '0;
      busy         <= 1'b0;
      period_count <= '0;
      cfg_err      <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (bus.cfg_enable && act_ok) begin
            cnt  <= '0;
            bank <= start_bank;
            busy <= 1'b1;
            if (act_on != '0) begin
              state   <= StOn;
              heat_en <= onehot(start_bank);
            end else begin
              state   <= StOff;
              heat_en <= '0;
            end
          end
        end
        StOn, StOff: begin
          if (!bus.cfg_enable) begin
            // Abandon the partial period; it is not counted.
            state   <= StIdle;
            heat_en <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            if (pend_valid) begin
              act_on     <= pend_on;
              act_period <= pend_period;
              act_mask   <= pend_mask;
              pend_valid <= 1'b0;
            end
          end else if (period_end) begin
            period_count <= period_count + CNT_W'(1);
            if (pend_valid) begin
              act_on     <= pend_on;
              act_period <= pend_period;
              act_mask   <= pend_mask;
              pend_valid <= 1'b0;
            end
            bank <= adv_bank;
            cnt  <= '0;
            if (nxt_on != '0) begin
              state   <= StOn;
              heat_en <= onehot(adv_bank);
            end else begin
              state   <= StOff;
              heat_en <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if ((state == StOn) && on_last && !full_on) begin
              state   <= StOff;
              heat_en <= '0;
            end
          end
        end
        default: begin
          state   <= StIdle;
          heat_en <= '0;
          busy    <= 1'b0;
        end
      endcase

      // Placed after the FSM so a load in a promotion cycle refills the
      // slot instead of being lost to the slot clear above.
      if (bus.cfg_load) begin
        if (!load_ok) begin
          cfg_err <= 1'b1;
        end else begin
          cfg_err <= 1'b0;
          if (state == StIdle) begin
            act_on     <= bus.cfg_on_cycles;
            act_period <= bus.cfg_period;
            act_mask   <= bus.cfg_bank_mask;
          end else begin
            pend_valid  <= 1'b1;
            pend_on     <= bus.cfg_on_cycles;
            pend_period <= bus.cfg_period;
            pend_mask   <= bus.cfg_bank_mask;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_heater_duty_scheduler.sv
// Bench for heater_duty_scheduler: a period-position model predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_heater_duty_scheduler;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  heater_duty_scheduler_if #(.N_BANKS(NB), .CNT_W(CW)) bus ();

  heater_duty_scheduler #(.N_BANKS(NB), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Model: running flag, position inside the period, current bank, configs.
  bit          m_run;
  int          m_pos;
  int          m_bank;
  int          m_on;
  int          m_per;
  logic [NB-1:0] m_mask;
  bit          p_val;
  int          p_on;
  int          p_per;
  logic [NB-1:0] p_mask;
  int          m_cnt;
  bit          m_err;
  bit          was_run;
  bit          ok;
  int          c_on;
  int          c_per;
  logic [NB-1:0] c_mask;
  int          exp_heat;

  // First set bank at or after start, scanning cyclically.
  function automatic int first_from(input logic [NB-1:0] mask, input int start);
    for (int k = 0; k < int'(NB); k++) begin
      if (mask[(start + k) % int'(NB)]) return (start + k) % int'(NB);
    end
    return 0;
  endfunction

  task automatic promote();
    if (p_val) begin
      m_on   = p_on;
      m_per  = p_per;
      m_mask = p_mask;
      p_val  = 1'b0;
    end
  endtask

  // Model step on every clock edge, then compare just after it.
  always begin
    @(posedge clock);
    c_on   = int'(bus.cfg_on_cycles);
    c_per  = int'(bus.cfg_period);
    c_mask = bus.cfg_bank_mask;
    ok     = (c_per != 0) && (c_on <= c_per) && (c_mask != '0);
    if (reset) begin
      m_run = 0; m_pos = 0; m_bank = 0; m_on = 0; m_per = 0; m_mask = '0;
      p_val = 0; p_on = 0; p_per = 0; p_mask = '0; m_cnt = 0; m_err = 0;
    end else begin
      was_run = m_run;
      if (!m_run) begin
        if (bus.cfg_enable && m_per != 0 && m_mask != '0) begin
          m_run  = 1;
          m_pos  = 0;
          m_bank = first_from(m_mask, 0);
        end
      end else if (!bus.cfg_enable) begin
        m_run = 0;
        promote();
      end else if (m_pos == m_per - 1) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        promote();
        m_bank = first_from(m_mask, m_bank + 1);
        m_pos  = 0;
      end else begin
        m_pos++;
      end
      if (bus.cfg_load) begin
        if (!ok) begin
          m_err = 1;
        end else begin
          m_err = 0;
          if (!was_run) begin
            m_on = c_on; m_per = c_per; m_mask = c_mask;
          end else begin
            p_val = 1; p_on = c_on; p_per = c_per; p_mask = c_mask;
          end
        end
      end
    end
    exp_heat = (m_run && m_pos < m_on) ? (1 << m_bank) : 0;
    #1;
    if (chk_en) begin
      check("model heat_en", 32'(bus.heat_en), 32'(exp_heat));
      check("model busy", 32'(bus.busy), 32'(m_run));
      check("model period_count", 32'(bus.period_count), 32'(m_cnt));
      check("model cfg_err", 32'(bus.cfg_err), 32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input int on, input int per, input logic [NB-1:0] mask);
    bus.cfg_on_cycles = CW'(on);
    bus.cfg_period    = CW'(per);
    bus.cfg_bank_mask = mask;
    bus.cfg_load      = 1'b1;
    tick(1);
    bus.cfg_load      = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.cfg_enable = 1'b0;
    tick(1);
    reset          = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.cfg_enable    = 1'b0;
    bus.cfg_load      = 1'b0;
    bus.cfg_on_cycles = '0;
    bus.cfg_period    = '0;
    bus.cfg_bank_mask = '0;
    tick(2);
    chk_en = 1'b1;
    check("reset heat_en", 32'(bus.heat_en), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset period_count", 32'(bus.period_count), 32'h0);
    check("reset cfg_err", 32'(bus.cfg_err), 32'h0);
    reset = 1'b0;

    // Basic schedule: on=3, period=8, all banks.
    load(3, 8, 4'b1111);
    bus.cfg_enable = 1'b1;
    tick(1);  check("basic start", 32'(bus.heat_en), 32'h1);
    tick(2);  check("basic on3", 32'(bus.heat_en), 32'h1);
    tick(1);  check("basic off", 32'(bus.heat_en), 32'h0);
    tick(5);  check("basic bank1", 32'(bus.heat_en), 32'h2);
              check("basic count1", 32'(bus.period_count), 32'd1);
    tick(8);  check("basic bank2", 32'(bus.heat_en), 32'h4);
    tick(8);  check("basic bank3", 32'(bus.heat_en), 32'h8);
    tick(8);  check("basic wrap", 32'(bus.heat_en), 32'h1);
              check("basic count4", 32'(bus.period_count), 32'd4);

    // Sparse mask, always-on duty, then on=0 reload.
    do_reset();
    load(5, 5, 4'b1010);
    bus.cfg_enable = 1'b1;
    tick(1);  check("sparse first", 32'(bus.heat_en), 32'h2);
    tick(4);  check("sparse no gap", 32'(bus.heat_en), 32'h2);
    tick(1);  check("sparse second", 32'(bus.heat_en), 32'h8);
    tick(5);  check("sparse back", 32'(bus.heat_en), 32'h2);
    load(0, 4, 4'b1111);
    tick(4);  check("zero-on heat", 32'(bus.heat_en), 32'h0);
              check("zero-on count3", 32'(bus.period_count), 32'd3);
              check("zero-on busy", 32'(bus.busy), 32'h1);
    tick(4);  check("zero-on count4", 32'(bus.period_count), 32'd4);

    // Mid-period reload.
    do_reset();
    load(2, 6, 4'b1111);
    bus.cfg_enable = 1'b1;
    tick(3);
    load(4, 4, 4'b1111);
    tick(2);  check("reload old tail", 32'(bus.heat_en), 32'h0);
    tick(1);  check("reload new on", 32'(bus.heat_en), 32'h2);
    tick(3);  check("reload full on", 32'(bus.heat_en), 32'h2);
    tick(1);  check("reload next bank", 32'(bus.heat_en), 32'h4);
              check("reload count2", 32'(bus.period_count), 32'd2);

    // Invalid loads while running.
    load(1, 0, 4'b1111);  check("err period0", 32'(bus.cfg_err), 32'h1);
    load(9, 8, 4'b1111);  check("err on>period", 32'(bus.cfg_err), 32'h1);
    load(1, 4, 4'b0000);  check("err mask0", 32'(bus.cfg_err), 32'h1);
                          check("err still busy", 32'(bus.busy), 32'h1);
    tick(3);
    load(2, 4, 4'b1111);  check("err cleared", 32'(bus.cfg_err), 32'h0);
    tick(10);

    // Stop, restart, reset mid-OFF.
    do_reset();
    load(3, 8, 4'b0110);
    bus.cfg_enable = 1'b1;
    tick(10);
    bus.cfg_enable = 1'b0;
    tick(1);  check("stop heat", 32'(bus.heat_en), 32'h0);
              check("stop busy", 32'(bus.busy), 32'h0);
              check("stop count", 32'(bus.period_count), 32'd1);
    bus.cfg_enable = 1'b1;
    tick(1);  check("restart lowest", 32'(bus.heat_en), 32'h2);
    tick(4);
    reset = 1'b1;
    tick(1);  check("mid reset heat", 32'(bus.heat_en), 32'h0);
              check("mid reset count", 32'(bus.period_count), 32'h0);
    reset = 1'b0;
    tick(3);  check("idle no cfg", 32'(bus.busy), 32'h0);
    load(3, 8, 4'b0110);
    tick(1);  check("start after load", 32'(bus.heat_en), 32'h2);
    tick(4);

    // Counter wrap with period=1.
    do_reset();
    load(1, 1, 4'b0001);
    bus.cfg_enable = 1'b1;
    tick(16); check("wrap count15", 32'(bus.period_count), 32'd15);
    tick(1);  check("wrap count0", 32'(bus.period_count), 32'd0);
              check("wrap heat", 32'(bus.heat_en), 32'h1);
    tick(3);

    bus.cfg_enable = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
